// File: rtl/button_encoder_pkg.sv
// Shared definitions for the button front end: direction codes, FSM states,
// stack data width and the direction priority helper.
package iron_violet_defs;

    localparam int DATA_WIDTH = 2;
    localparam int NUM_INPUTS = 5;
    localparam int UNDO_IDX   = 4;

    localparam logic [DATA_WIDTH-1:0] DIR_UP    = 2'd0;
    localparam logic [DATA_WIDTH-1:0] DIR_RIGHT = 2'd1;
    localparam logic [DATA_WIDTH-1:0] DIR_DOWN  = 2'd2;
    localparam logic [DATA_WIDTH-1:0] DIR_LEFT  = 2'd3;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } state_t;

    // Lowest-numbered pressed direction wins; caller guarantees press != 0.
    function automatic logic [DATA_WIDTH-1:0] first_dir(input logic [3:0] press);
        first_dir = DIR_LEFT;
        if (press[2]) first_dir = DIR_DOWN;
        if (press[1]) first_dir = DIR_RIGHT;
        if (press[0]) first_dir = DIR_UP;
    endfunction

endpackage

// File: rtl/button_encoder_if.sv
// Player-side buttons, stack flags and the command strobes toward the move stack.
interface button_encoder_if;
    import iron_violet_defs::*;

    // Strobes carry no back-pressure: one cycle of PUSH/POP/REJECT is a complete
    // transfer, DATA_OUT is meaningful only while PUSH=1 and holds otherwise.
    logic [3:0]            BTN;
    logic                  UNDO;
    logic                  FULL;
    logic                  EMPTY;
    logic                  PUSH;
    logic                  POP;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  REJECT;
    state_t                dbg_state;

    modport master (
        output BTN, UNDO, FULL, EMPTY,
        input  PUSH, POP, DATA_OUT, REJECT, dbg_state
    );

    modport slave (
        input  BTN, UNDO, FULL, EMPTY,
        output PUSH, POP, DATA_OUT, REJECT, dbg_state
    );

endinterface

// File: rtl/button_encoder_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level only
// follows the input after DB_CYCLES consecutive disagreeing samples.
module debounce #(
    parameter int DB_CYCLES = 15,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_encoder.sv
// Turns debounced button presses into single-cycle PUSH/POP/REJECT strobes,
// arbitrating simultaneous presses and locking out chords until all release.
module button_encoder
    import iron_violet_defs::*;
#(
    parameter int DB_CYCLES = 15,
    parameter int CNT_W     = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    button_encoder_if.slave  bus
);

    logic [NUM_INPUTS-1:0] raw;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] level_prev;
    logic [NUM_INPUTS-1:0] press;

    assign raw = {bus.UNDO, bus.BTN};

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_db
        debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk   (CLK),
            .rst_n (RST_N),
            .raw   (raw[gi]),
            .level (level[gi])
        );
    end

    // Only rising edges of the debounced levels count; releases are ignored.
    assign press = level & ~level_prev;

    state_t                state;
    state_t                state_next;
    logic                  push_q,  push_d;
    logic                  pop_q,   pop_d;
    logic                  reject_q, reject_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            level_prev <= '0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            reject_q   <= 1'b0;
            data_q     <= '0;
        end else begin
            state      <= state_next;
            level_prev <= level;
            push_q     <= push_d;
            pop_q      <= pop_d;
            reject_q   <= reject_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_next = state;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        reject_d   = 1'b0;
        data_d     = data_q;
        case (state)
            IDLE: begin
                // UNDO outranks every direction; losing presses vanish silently.
                if (press[UNDO_IDX]) begin
                    if (!bus.EMPTY) pop_d = 1'b1;
                    else            reject_d = 1'b1;
                    state_next = WAIT_REL;
                end else if (|press[3:0]) begin
                    if (!bus.FULL) begin
                        push_d = 1'b1;
                        data_d = first_dir(press[3:0]);
                    end else begin
                        reject_d = 1'b1;
                    end
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (|press) reject_d = 1'b1;
                if (level == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.PUSH      = push_q;
    assign bus.POP       = pop_q;
    assign bus.REJECT    = reject_q;
    assign bus.DATA_OUT  = data_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder: a raw-history reference model
// predicts every output cycle; scenario tasks check counts and timing.
module tb_button_encoder;
    import iron_violet_defs::*;

    localparam int DB    = 4;
    localparam int CW    = 4;
    localparam int DEPTH = 16;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    button_encoder_if bus ();

    button_encoder #(
        .DB_CYCLES (DB),
        .CNT_W     (CW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [4:0] m_level = '0;
    logic [4:0] m_prev  = '0;
    logic [4:0] m_d1    = '0;
    logic [4:0] m_d2    = '0;
    logic [4:0] m_hist[$];
    logic       m_busy  = 1'b0;
    logic       m_push  = 1'b0;
    logic       m_pop   = 1'b0;
    logic       m_rej   = 1'b0;
    logic [1:0] m_data  = '0;
    logic [4:0] exp_q[$];

    task automatic model_clear();
        m_level = '0; m_prev = '0; m_d1 = '0; m_d2 = '0;
        m_hist.delete();
        m_busy = 1'b0; m_push = 1'b0; m_pop = 1'b0; m_rej = 1'b0; m_data = '0;
        exp_q.delete();
    endtask

    // A level flips once the last DB synchronised samples all disagree with it.
    task automatic model_step();
        logic [4:0] press;
        logic       was_busy;
        logic       all_diff;
        press    = m_level & ~m_prev;
        was_busy = m_busy;
        m_push = 1'b0; m_pop = 1'b0; m_rej = 1'b0;
        if (was_busy) begin
            if (press != 5'b0) m_rej = 1'b1;
            if (m_level == 5'b0) m_busy = 1'b0;
        end else if (press != 5'b0) begin
            m_busy = 1'b1;
            if (press[4]) begin
                if (bus.EMPTY) m_rej = 1'b1;
                else           m_pop = 1'b1;
            end else if (bus.FULL) begin
                m_rej = 1'b1;
            end else begin
                m_push = 1'b1;
                for (int k = 3; k >= 0; k--) if (press[k]) m_data = 2'(k);
            end
        end
        if (m_push | m_pop | m_rej) exp_q.push_back({m_push, m_pop, m_rej, m_data});
        m_prev = m_level;
        m_hist.push_back(m_d2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        if (m_hist.size() == DB) begin
            for (int j = 0; j < 5; j++) begin
                all_diff = 1'b1;
                for (int k = 0; k < m_hist.size(); k++)
                    if (m_hist[k][j] == m_level[j]) all_diff = 1'b0;
                if (all_diff) m_level[j] = ~m_level[j];
            end
        end
        m_d2 = m_d1;
        m_d1 = {bus.UNDO, bus.BTN};
    endtask

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) model_clear();
        else        model_step();
    end

    // ---------------- stack environment ----------------
    logic stack_mode = 1'b0;
    int   stk_cnt    = 0;

    always @(posedge CLK) begin
        if (!stack_mode) stk_cnt <= 0;
        else             stk_cnt <= stk_cnt + int'(bus.PUSH) - int'(bus.POP);
    end

    // ---------------- observation ----------------
    int o_cyc, o_push, o_pop, o_rej, o_mis, o_first;

    task automatic clear_obs();
        o_cyc = 0; o_push = 0; o_pop = 0; o_rej = 0; o_mis = 0; o_first = 0;
    endtask

    task automatic observe_cycle();
        logic [4:0] got;
        @(negedge CLK);
        o_cyc++;
        got = {bus.PUSH, bus.POP, bus.REJECT, bus.DATA_OUT};
        if (got !== {m_push, m_pop, m_rej, m_data}) o_mis++;
        if (bus.PUSH | bus.POP | bus.REJECT) begin
            if (o_first == 0) o_first = o_cyc;
            o_push += int'(bus.PUSH);
            o_pop  += int'(bus.POP);
            o_rej  += int'(bus.REJECT);
            if (exp_q.size() == 0) o_mis++;
            else if (exp_q.pop_front() !== got) o_mis++;
        end
        if (stack_mode) begin
            bus.FULL  = (stk_cnt >= DEPTH);
            bus.EMPTY = (stk_cnt == 0);
        end
    endtask

    task automatic drive_window(input logic [3:0] btn, input logic undo, input int hold,
                                input logic [3:0] rbtn, input logic rundo, input int rel);
        bus.BTN = btn; bus.UNDO = undo;
        clear_obs();
        repeat (hold) observe_cycle();
        bus.BTN = rbtn; bus.UNDO = rundo;
        repeat (rel) observe_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.BTN = '0; bus.UNDO = 1'b0; bus.FULL = 1'b0; bus.EMPTY = 1'b1;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.PUSH, bus.POP, bus.REJECT, bus.DATA_OUT} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {bus.PUSH, bus.POP, bus.REJECT, bus.DATA_OUT});
        end
        checks++;
        if (bus.dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
        end
        RST_N = 1'b1;
        clear_obs();
        repeat (4) observe_cycle();
        checks++;
        if (o_push + o_pop + o_rej != 0 || o_mis != 0) begin
            errors++; $display("FAIL reset_quiet: strobes %0d mismatches %0d expected 0 0", o_push + o_pop + o_rej, o_mis);
        end
    endtask

    task automatic test_press_latency();
        drive_window(4'b0100, 1'b0, 20, 4'b0000, 1'b0, 12);
        checks++;
        if (o_push != 1) begin errors++; $display("FAIL latency_count: got %0d pushes expected 1", o_push); end
        checks++;
        if (o_first != DB + 3) begin errors++; $display("FAIL latency_edge: got cycle %0d expected %0d", o_first, DB + 3); end
        checks++;
        if (bus.DATA_OUT !== DIR_DOWN) begin errors++; $display("FAIL latency_data: got %0d expected 2", bus.DATA_OUT); end
        checks++;
        if (o_mis != 0) begin errors++; $display("FAIL latency_model: %0d mismatching cycles expected 0", o_mis); end
        checks++;
        if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL release_idle: got %0d expected %0d", bus.dbg_state, IDLE); end
        drive_window(4'b0100, 1'b0, 15, 4'b0000, 1'b0, 12);
        checks++;
        if (o_push != 1 || o_rej != 0) begin errors++; $display("FAIL second_press: got push %0d reject %0d expected 1 0", o_push, o_rej); end
        checks++;
        if (bus.DATA_OUT !== DIR_DOWN) begin errors++; $display("FAIL second_data: got %0d expected 2", bus.DATA_OUT); end
    endtask

    task automatic test_glitch();
        int strobes = 0;
        int mis = 0;
        for (int rep = 0; rep < 5; rep++) begin
            drive_window(4'b0010, 1'b0, 3, 4'b0000, 1'b0, 6);
            strobes += o_push + o_pop + o_rej;
            mis += o_mis;
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes expected 0", strobes); end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL glitch_model: %0d mismatching cycles expected 0", mis); end
    endtask

    task automatic test_reject();
        bus.FULL = 1'b1;
        drive_window(4'b1000, 1'b0, 12, 4'b0000, 1'b0, 12);
        checks++;
        if (o_rej != 1 || o_push != 0) begin errors++; $display("FAIL full_reject: got reject %0d push %0d expected 1 0", o_rej, o_push); end
        checks++;
        if (bus.DATA_OUT !== DIR_DOWN) begin errors++; $display("FAIL full_data_hold: got %0d expected 2", bus.DATA_OUT); end
        bus.FULL = 1'b0; bus.EMPTY = 1'b1;
        drive_window(4'b0000, 1'b1, 12, 4'b0000, 1'b0, 12);
        checks++;
        if (o_rej != 1 || o_pop != 0) begin errors++; $display("FAIL empty_reject: got reject %0d pop %0d expected 1 0", o_rej, o_pop); end
        bus.EMPTY = 1'b0;
        drive_window(4'b0000, 1'b1, 12, 4'b0000, 1'b0, 12);
        checks++;
        if (o_pop != 1 || o_rej != 0) begin errors++; $display("FAIL undo_pop: got pop %0d reject %0d expected 1 0", o_pop, o_rej); end
        checks++;
        if (o_mis != 0) begin errors++; $display("FAIL reject_model: %0d mismatching cycles expected 0", o_mis); end
    endtask

    task automatic test_arbitration();
        bus.FULL = 1'b0; bus.EMPTY = 1'b0;
        drive_window(4'b0001, 1'b1, 12, 4'b0000, 1'b1, 4);
        checks++;
        if (o_pop != 1 || o_push != 0 || o_rej != 0) begin
            errors++; $display("FAIL same_cycle_arb: got pop %0d push %0d reject %0d expected 1 0 0", o_pop, o_push, o_rej);
        end
        checks++;
        if (bus.dbg_state !== WAIT_REL) begin errors++; $display("FAIL held_state: got %0d expected %0d", bus.dbg_state, WAIT_REL); end
        drive_window(4'b0010, 1'b1, 12, 4'b0000, 1'b0, 12);
        checks++;
        if (o_rej != 1 || o_push != 0 || o_pop != 0) begin
            errors++; $display("FAIL chord_lockout: got reject %0d push %0d pop %0d expected 1 0 0", o_rej, o_push, o_pop);
        end
        drive_window(4'b0010, 1'b0, 12, 4'b0000, 1'b0, 12);
        checks++;
        if (o_push != 1 || bus.DATA_OUT !== DIR_RIGHT) begin
            errors++; $display("FAIL after_chord_push: got push %0d data %0d expected 1 1", o_push, bus.DATA_OUT);
        end
        checks++;
        if (o_mis != 0) begin errors++; $display("FAIL arb_model: %0d mismatching cycles expected 0", o_mis); end
    endtask

    task automatic test_reset_mid();
        bus.BTN = 4'b0001;
        clear_obs();
        repeat (3) observe_cycle();
        RST_N = 1'b0;
        #1;
        checks++;
        if ({bus.PUSH, bus.POP, bus.REJECT, bus.DATA_OUT} !== 5'b0 || bus.dbg_state !== IDLE) begin
            errors++; $display("FAIL mid_debounce_reset: got %b state %0d expected 00000 0", {bus.PUSH, bus.POP, bus.REJECT, bus.DATA_OUT}, bus.dbg_state);
        end
        observe_cycle();
        RST_N = 1'b1;
        clear_obs();
        repeat (16) observe_cycle();
        checks++;
        if (o_push != 1 || o_first != DB + 3) begin
            errors++; $display("FAIL held_through_reset: got push %0d at cycle %0d expected 1 at %0d", o_push, o_first, DB + 3);
        end
        checks++;
        if (bus.DATA_OUT !== DIR_UP || o_mis != 0) begin
            errors++; $display("FAIL held_reset_data: got data %0d mismatches %0d expected 0 0", bus.DATA_OUT, o_mis);
        end
        bus.BTN = 4'b0000;
        repeat (12) observe_cycle();
        bus.BTN = 4'b1000;
        clear_obs();
        while (o_push == 0 && o_cyc < 20) observe_cycle();
        checks++;
        if (bus.PUSH !== 1'b1 || bus.DATA_OUT !== DIR_LEFT) begin
            errors++; $display("FAIL strobe_before_reset: got push %b data %0d expected 1 3", bus.PUSH, bus.DATA_OUT);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.PUSH !== 1'b0 || bus.DATA_OUT !== 2'd0) begin
            errors++; $display("FAIL reset_mid_strobe: got push %b data %0d expected 0 0", bus.PUSH, bus.DATA_OUT);
        end
        observe_cycle();
        RST_N = 1'b1;
        bus.BTN = 4'b0000;
        clear_obs();
        repeat (12) observe_cycle();
        checks++;
        if (o_push + o_pop + o_rej != 0 || o_mis != 0) begin
            errors++; $display("FAIL post_reset_quiet: strobes %0d mismatches %0d expected 0 0", o_push + o_pop + o_rej, o_mis);
        end
    endtask

    task automatic test_random();
        int         hold_c[5];
        logic [4:0] r = '0;
        int         strobes;
        for (int i = 0; i < 5; i++) hold_c[i] = $urandom_range(5, 30);
        clear_obs();
        for (int c = 0; c < 600; c++) begin
            observe_cycle();
            for (int i = 0; i < 5; i++) begin
                hold_c[i]--;
                if (hold_c[i] <= 0) begin
                    r[i] = ~r[i];
                    hold_c[i] = r[i] ? $urandom_range(1, 10) : $urandom_range(5, 30);
                end
            end
            if ($urandom_range(0, 15) == 0) bus.FULL  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.EMPTY = 1'($urandom_range(0, 1));
            bus.BTN  = r[3:0];
            bus.UNDO = r[4];
        end
        bus.BTN = 4'b0000; bus.UNDO = 1'b0;
        repeat (15) observe_cycle();
        strobes = o_push + o_pop + o_rej;
        checks++;
        if (o_mis != 0) begin errors++; $display("FAIL random_model: %0d mismatching cycles expected 0", o_mis); end
        checks++;
        if (strobes == 0) begin errors++; $display("FAIL random_activity: got %0d strobes expected >0", strobes); end
    endtask

    task automatic test_stack();
        int np = 0, npop = 0, nrej = 0, mis = 0;
        int last_rej_push = 0, last_rej_pop = 0;
        bus.FULL = 1'b0; bus.EMPTY = 1'b1;
        stack_mode = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_window(4'(1 << (i % 4)), 1'b0, 10, 4'b0000, 1'b0, 10);
            np += o_push; nrej += o_rej; mis += o_mis;
            if (i == DEPTH) last_rej_push = o_rej;
        end
        checks++;
        if (np != DEPTH || nrej != 1 || last_rej_push != 1) begin
            errors++; $display("FAIL stack_fill: got push %0d reject %0d last %0d expected 16 1 1", np, nrej, last_rej_push);
        end
        checks++;
        if (stk_cnt != DEPTH) begin errors++; $display("FAIL stack_level_full: got %0d expected 16", stk_cnt); end
        nrej = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_window(4'b0000, 1'b1, 10, 4'b0000, 1'b0, 10);
            npop += o_pop; nrej += o_rej; mis += o_mis;
            if (i == DEPTH) last_rej_pop = o_rej;
        end
        checks++;
        if (npop != DEPTH || nrej != 1 || last_rej_pop != 1) begin
            errors++; $display("FAIL stack_drain: got pop %0d reject %0d last %0d expected 16 1 1", npop, nrej, last_rej_pop);
        end
        checks++;
        if (stk_cnt != 0 || mis != 0) begin
            errors++; $display("FAIL stack_model: level %0d mismatches %0d expected 0 0", stk_cnt, mis);
        end
        stack_mode = 1'b0;
    endtask

    task automatic test_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d expected strobes never seen, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_reject();
        test_arbitration();
        test_reset_mid();
        test_random();
        test_stack();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_encoder.md
Name: button_encoder

Overview:
Front end that turns raw player buttons into stack commands. It synchronises and debounces four direction buttons and one UNDO button, then emits single-cycle PUSH (with a 2-bit direction code) or POP pulses. These pulses drive the move stack directly. It also flags presses that were dropped because the stack was full or empty, or because another button was already held.

Parameters:
DB_CYCLES, 15, consecutive stable synchronised cycles required before a debounced level changes; must be >=1 and < 2**CNT_W.
CNT_W, 4, debounce counter width, set by hand (no clog2).

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
BTN  in  4  raw direction buttons, active-high, asynchronous; index = direction code (0 UP, 1 RIGHT, 2 DOWN, 3 LEFT).
UNDO  in  1  raw undo button, active-high, asynchronous.
FULL  in  1  stack full flag.
EMPTY  in  1  stack empty flag.
PUSH  out  1  registered one-cycle push strobe.
POP  out  1  registered one-cycle pop strobe.
DATA_OUT  out  2  registered direction code; valid when PUSH=1, holds last value otherwise.
REJECT  out  1  registered one-cycle pulse: a press was recognised but not issued.

Behaviour:
- Reset (async assert, sync-safe deassert assumed upstream): PUSH=0, POP=0, DATA_OUT=0, REJECT=0; sync flops, debounced levels and counters =0; FSM=IDLE.
- Sync: each of 5 inputs passes through a 2-flop synchroniser.
- Debounce, per input:
  - Counter clears whenever the synchronised value equals the debounced level.
  - On mismatch the counter increments.
  - The debounced level flips at the edge where a mismatch is seen with counter==DB_CYCLES-1; the counter clears at the same edge.
  - Glitches shorter than DB_CYCLES cycles never change the level.
- Press event: rising edge of a debounced level (registered previous level vs current). Release events are ignored.
- Latency: for a clean raw 0->1, PUSH/POP/REJECT is high in the cycle following the (DB_CYCLES+3)th rising edge that samples raw high.
- FSM states: IDLE, WAIT_REL.
  - IDLE, no press: outputs stay 0.
  - IDLE, >=1 press same cycle: arbitrate UNDO > BTN[0] > BTN[1] > BTN[2] > BTN[3]; losers are discarded silently.
  - Winner UNDO: if !EMPTY assert POP, else assert REJECT.
  - Winner BTN[i]: if !FULL assert PUSH and load DATA_OUT=i, else assert REJECT.
  - From IDLE with any winner, go to WAIT_REL.
  - WAIT_REL: any new press event asserts REJECT for one cycle and issues no command (chord lockout). Return to IDLE when all 5 debounced levels are 0.
- Strobes are exactly one cycle. PUSH, POP and REJECT are mutually exclusive in any cycle.
- FULL/EMPTY are sampled in the same cycle the press event is evaluated. The one-cycle stack flag lag is harmless because commands are at least 2 cycles apart (WAIT_REL).
- A button held through reset deassertion is seen as 0->1 after debounce and produces one normal press.
- Reset asserted mid-strobe clears the strobe immediately.

Decomposition:
- Shared package/include (iron_violet_defs): direction code constants DIR_UP=2'd0, DIR_RIGHT=2'd1, DIR_DOWN=2'd2, DIR_LEFT=2'd3; FSM state encodings; stack DATA_WIDTH=2.
- Sub-module: debounce (synchroniser + counter + level register, parameters DB_CYCLES/CNT_W), instantiated 5 times. Arbitration and FSM stay in button_encoder.

Test Plan:
- DB_CYCLES=4, FULL=0: raise BTN[2] and hold -> exactly one PUSH pulse with DATA_OUT=2, 7 edges after first sampling; release, press again -> second PUSH, DATA_OUT=2.
- DB_CYCLES=4: BTN[1] high for 3 cycles, then low for 6, repeated 5x -> no PUSH, POP or REJECT ever.
- Press BTN[3] with FULL=1 -> REJECT one cycle, PUSH=0, DATA_OUT unchanged. UNDO with EMPTY=1 -> REJECT, POP=0. UNDO with EMPTY=0 -> POP one cycle.
- BTN[0] and UNDO rise in the same cycle -> POP only; BTN[0] discarded, no REJECT. Hold UNDO, then press BTN[1] -> REJECT. Release all, press BTN[1] -> PUSH, DATA_OUT=1.
- Hold BTN[0], pulse RST_N low for 1 cycle mid-debounce -> outputs 0 asynchronously during reset; after release exactly one PUSH with DATA_OUT=0 after full debounce latency.
- Connect to stack (DEPTH=16), press 17 distinct directions -> 16 PUSH then REJECT; 17 UNDO presses -> 16 POP then REJECT.
